// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall control for a 5-stage pipeline.
// Handles load-use bubbles, dmem wait stalls with timeout, branch flushes, and saturating counters.
module hazard_stall_unit #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNTW        = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      IF_ID_rs1,
   input  logic [4:0]      IF_ID_rs2,
   input  logic            IF_ID_use_rs1,
   input  logic            IF_ID_use_rs2,
   input  logic            ID_EX_memread,
   input  logic [4:0]      ID_EX_rd,
   input  logic            EX_MEM_memread,
   input  logic            EX_MEM_memwrite,
   input  logic            dmem_ready,
   input  logic            branch_taken,
   output logic            pc_stall,
   output logic            IF_ID_stall,
   output logic            ID_EX_stall,
   output logic            EX_MEM_stall,
   output logic            ID_EX_bubble,
   output logic            MEM_WB_bubble,
   output logic            IF_ID_flush,
   output logic            ID_EX_flush,
   output logic            mem_err,
   output logic [CNTW-1:0] stall_cycles,
   output logic [CNTW-1:0] flush_count
);

   localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] TIMEOUT_VAL = WCW'(MEM_TIMEOUT);
   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

   typedef enum logic {RUN, MEMWAIT} state_t;

   state_t         state;
   logic [WCW-1:0] wait_cnt;
   logic           load_use;
   logic           mem_acc;
   logic           timeout_now;
   logic           mem_busy;

   always_comb begin
      load_use = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                 ((IF_ID_use_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                  (IF_ID_use_rs2 && (ID_EX_rd == IF_ID_rs2)));
      mem_acc     = EX_MEM_memread || EX_MEM_memwrite;
      timeout_now = (state == MEMWAIT) && (wait_cnt == TIMEOUT_VAL);
      mem_busy    = mem_acc && !dmem_ready && !timeout_now;
   end

   // A frozen pipeline hides branch and load-use; they are seen again once memory releases.
   always_comb begin
      pc_stall      = 1'b0;
      IF_ID_stall   = 1'b0;
      ID_EX_stall   = 1'b0;
      EX_MEM_stall  = 1'b0;
      ID_EX_bubble  = 1'b0;
      MEM_WB_bubble = 1'b0;
      IF_ID_flush   = 1'b0;
      ID_EX_flush   = 1'b0;
      if (!rst) begin
         if (mem_busy) begin
            pc_stall      = 1'b1;
            IF_ID_stall   = 1'b1;
            ID_EX_stall   = 1'b1;
            EX_MEM_stall  = 1'b1;
            MEM_WB_bubble = 1'b1;
         end else if (branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
         end else if (load_use) begin
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         wait_cnt     <= '0;
         mem_err      <= 1'b0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         case (state)
            RUN: begin
               if (mem_busy) begin
                  state    <= MEMWAIT;
                  wait_cnt <= WCW'(1);
               end
            end
            MEMWAIT: begin
               // A timed-out access is abandoned as if it had completed.
               if (timeout_now) begin
                  mem_err  <= 1'b1;
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (mem_busy) begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end else begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
         if (pc_stall && (stall_cycles != CNT_MAX))
            stall_cycles <= stall_cycles + CNTW'(1);
         if (IF_ID_flush && (flush_count != CNT_MAX))
            flush_count <= flush_count + CNTW'(1);
      end
   end

endmodule
